// File: rtl/vga_timing_gen_if.sv
// Bus between the VGA timing generator and its pixel source / display sink.
interface vga_timing_gen_if #(
  parameter int unsigned COLOR_W = 3,
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned CNT_W   = 11
);
  logic               iEnable;
  logic [COLOR_W-1:0] iColor;
  logic               oHs;
  logic               oVs;
  logic [COLOR_W-1:0] oRGB;
  logic               oActive;
  logic [ADDR_W-1:0]  oColorAddress;
  logic               oFrameStart;
  logic [CNT_W-1:0]   oHCount;
  logic [CNT_W-1:0]   oVCount;

  modport master (
    input  iEnable, iColor,
    output oHs, oVs, oRGB, oActive, oColorAddress, oFrameStart, oHCount, oVCount
  );

  modport slave (
    output iEnable, iColor,
    input  oHs, oVs, oRGB, oActive, oColorAddress, oFrameStart, oHCount, oVCount
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v counters, syncs, active window
// and a frame-buffer address generated by counting visible pixels.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned COLOR_W  = 3,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned CNT_W    = 11,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input logic               Clock,
  input logic               Reset,
  vga_timing_gen_if.master  bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]  div;
  logic [CNT_W-1:0]  hc;
  logic [CNT_W-1:0]  vc;
  logic [ADDR_W-1:0] pixCnt;

  logic pe;
  logic hWrap;
  logic vWrap;
  logic active;
  logic hSync;
  logic vSync;

  // Decode of the current raster position
  always_comb begin
    pe     = (div == DIV_W'(CLK_DIV - 1));
    hWrap  = (hc == CNT_W'(H_TOTAL - 1));
    vWrap  = (vc == CNT_W'(V_TOTAL - 1));
    active = (hc < CNT_W'(H_ACTIVE)) && (vc < CNT_W'(V_ACTIVE));
    hSync  = (hc >= CNT_W'(H_ACTIVE + H_FP)) &&
             (hc <= CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1));
    vSync  = (vc >= CNT_W'(V_ACTIVE + V_FP)) &&
             (vc <= CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1));
  end

  assign bus.oHCount = hc;
  assign bus.oVCount = vc;

  // pixCnt always holds vc*H_ACTIVE+hc while the position is visible
  always_ff @(posedge Clock) begin
    if (!Reset || !bus.iEnable) begin
      div               <= '0;
      hc                <= '0;
      vc                <= '0;
      pixCnt            <= '0;
      bus.oHs           <= ~HS_POL;
      bus.oVs           <= ~VS_POL;
      bus.oRGB          <= '0;
      bus.oActive       <= 1'b0;
      bus.oColorAddress <= '0;
      bus.oFrameStart   <= 1'b0;
    end else begin
      div <= pe ? '0 : div + DIV_W'(1);
      if (pe) begin
        if (hWrap) begin
          hc <= '0;
          vc <= vWrap ? '0 : vc + CNT_W'(1);
        end else begin
          hc <= hc + CNT_W'(1);
        end
        if (hWrap && vWrap) begin
          pixCnt <= '0;
        end else if (active) begin
          pixCnt <= pixCnt + ADDR_W'(1);
        end
      end
      bus.oHs         <= hSync ? HS_POL : ~HS_POL;
      bus.oVs         <= vSync ? VS_POL : ~VS_POL;
      bus.oActive     <= active;
      bus.oRGB        <= active ? bus.iColor : '0;
      bus.oFrameStart <= pe && (hc == '0) && (vc == '0);
      if (active) begin
        bus.oColorAddress <= pixCnt;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a tiny 8x6 raster: two instances (divide-by-2
// active-low syncs, divide-by-1 active-high syncs) checked every clock.
module tb_vga_timing_gen;

  localparam int unsigned HT = 8;
  localparam int unsigned VT = 6;

  typedef struct {
    bit hs;
    bit vs;
    bit act;
    bit fs;
    int rgb;
    int addr;
    int hc;
    int vc;
  } exp_t;

  logic       Clock;
  logic       Reset;
  logic       en;
  logic [2:0] col;

  int nChecks = 0;
  int nPass   = 0;
  int k       = 0;
  int cyc     = 0;
  int last0   = 0;
  int last1   = 0;
  exp_t e0, e1;

  vga_timing_gen_if #(.COLOR_W(3), .ADDR_W(4), .CNT_W(4)) b0 ();
  vga_timing_gen_if #(.COLOR_W(3), .ADDR_W(4), .CNT_W(4)) b1 ();

  assign b0.iEnable = en;
  assign b0.iColor  = col;
  assign b1.iEnable = en;
  assign b1.iColor  = col;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(2), .COLOR_W(3), .ADDR_W(4), .CNT_W(4),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut0 (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (b0)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .COLOR_W(3), .ADDR_W(4), .CNT_W(4),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut1 (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (b1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else nPass++;
  endtask

  // Closed-form expectation from k = clock edges since the last reset/idle edge
  function automatic void model(input int kk, input int d, input bit hp, input bit vp,
                                input logic [2:0] c, inout int lastAddr, output exp_t e);
    int n, ph, pv, n2;
    if (kk == 0) begin
      lastAddr = 0;
      e = '{hs: ~hp, vs: ~vp, act: 1'b0, fs: 1'b0, rgb: 0, addr: 0, hc: 0, vc: 0};
    end else begin
      n  = (kk - 1) / d;
      ph = n % HT;
      pv = (n / HT) % VT;
      n2 = kk / d;
      e.act = (ph < 4) && (pv < 3);
      e.hs  = (ph == 5 || ph == 6) ? hp : ~hp;
      e.vs  = (pv == 4) ? vp : ~vp;
      if (e.act) lastAddr = pv * 4 + ph;
      e.addr = lastAddr;
      e.rgb  = e.act ? int'(c) : 0;
      e.fs   = (((kk - 1) % d) == d - 1) && ((n % (HT * VT)) == 0);
      e.hc   = n2 % HT;
      e.vc   = (n2 / HT) % VT;
    end
  endfunction

  task automatic checkOut(input string who, input exp_t e, input logic hs, input logic vs,
                          input logic act, input logic fs, input logic [2:0] rgb,
                          input logic [3:0] addr, input logic [3:0] hc, input logic [3:0] vc);
    check({who, ".hs"},   32'(hs),   32'(e.hs));
    check({who, ".vs"},   32'(vs),   32'(e.vs));
    check({who, ".act"},  32'(act),  32'(e.act));
    check({who, ".fs"},   32'(fs),   32'(e.fs));
    check({who, ".rgb"},  32'(rgb),  32'(e.rgb));
    check({who, ".addr"}, 32'(addr), 32'(e.addr));
    check({who, ".hc"},   32'(hc),   32'(e.hc));
    check({who, ".vc"},   32'(vc),   32'(e.vc));
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare
  task automatic step();
    @(posedge Clock);
    if (!Reset || !en) k = 0;
    else k++;
    model(k, 2, 1'b0, 1'b0, col, last0, e0);
    model(k, 1, 1'b1, 1'b1, col, last1, e1);
    #1;
    checkOut("d0", e0, b0.oHs, b0.oVs, b0.oActive, b0.oFrameStart, b0.oRGB,
             b0.oColorAddress, b0.oHCount, b0.oVCount);
    checkOut("d1", e1, b1.oHs, b1.oVs, b1.oActive, b1.oFrameStart, b1.oRGB,
             b1.oColorAddress, b1.oHCount, b1.oVCount);
    cyc++;
  endtask

  initial begin
    int fs0 = 0, fs1 = 0, t0a = 0, t0b = 0, t1a = 0, t1b = 0;
    int actCnt = 0, rgbCnt = 0, hsLow = 0, vsLow = 0, maxAddr = 0;
    bit found;

    Reset = 1'b0;
    en    = 1'b1;
    col   = 3'b101;
    repeat (3) step();
    check("rst.d0.hs", 32'(b0.oHs), 32'd1);
    check("rst.d0.addr", 32'(b0.oColorAddress), 32'd0);

    Reset = 1'b1;
    cyc   = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (b0.oFrameStart) begin
        fs0++;
        if (fs0 == 1) t0a = cyc;
        if (fs0 == 2) t0b = cyc;
      end
      if (b1.oFrameStart) begin
        fs1++;
        if (fs1 == 1) t1a = cyc;
        if (fs1 == 2) t1b = cyc;
      end
      if (fs0 == 1) begin
        if (b0.oActive) actCnt++;
        if (b0.oActive && b0.oRGB == 3'b101) rgbCnt++;
        if (!b0.oHs) hsLow++;
        if (!b0.oVs) vsLow++;
        if (int'(b0.oColorAddress) > maxAddr) maxAddr = int'(b0.oColorAddress);
      end
    end
    check("first_fs_d0", 32'(t0a), 32'd2);
    check("first_fs_d1", 32'(t1a), 32'd1);
    check("period_d0", 32'(t0b - t0a), 32'd96);
    check("period_d1", 32'(t1b - t1a), 32'd48);
    check("active_clks", 32'(actCnt), 32'd24);
    check("rgb_clks", 32'(rgbCnt), 32'd24);
    check("hs_low_clks", 32'(hsLow), 32'd24);
    check("vs_low_clks", 32'(vsLow), 32'd16);
    check("max_addr", 32'(maxAddr), 32'd11);

    for (int i = 0; i < 40; i++) begin
      col = 3'(i % 8);
      step();
    end

    // Mid-frame reset pulse at hc=2, vc=1
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (b0.oHCount == 4'd2 && b0.oVCount == 4'd1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("wait_hc2_vc1", 32'(found), 32'd1);
    Reset = 1'b0;
    step();
    check("pulse.hs", 32'(b0.oHs), 32'd1);
    check("pulse.act", 32'(b0.oActive), 32'd0);
    check("pulse.hc", 32'(b0.oHCount), 32'd0);
    Reset = 1'b1;
    step();
    step();
    check("pulse.fs", 32'(b0.oFrameStart), 32'd1);

    repeat (60) step();
    en = 1'b0;
    repeat (10) step();
    check("idle.vs", 32'(b0.oVs), 32'd1);
    check("idle.rgb", 32'(b0.oRGB), 32'd0);
    en = 1'b1;
    step();
    check("reen.fs_d1", 32'(b1.oFrameStart), 32'd1);
    step();
    check("reen.fs_d0", 32'(b0.oFrameStart), 32'd1);
    repeat (100) step();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
